// File: rtl/toggle_ram_responder.sv
// Toggle-handshake RAM responder: two requester ports share one 16-bit block RAM
// with a fixed grant-to-completion latency that mimics the SDRAM controller.
module toggle_ram_responder #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 4   // legal range 2..15
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              port1_req,
  output logic              port1_ack,
  input  logic [ADDR_W-1:0] port1_a,
  input  logic [1:0]        port1_ds,
  input  logic              port1_we,
  input  logic [15:0]       port1_d,
  output logic [15:0]       port1_q,
  input  logic              port2_req,
  output logic              port2_ack,
  input  logic [ADDR_W-1:0] port2_a,
  input  logic [1:0]        port2_ds,
  input  logic              port2_we,
  input  logic [15:0]       port2_d,
  output logic [15:0]       port2_q,
  output logic              busy
);

  localparam int WORDS = 2 ** (ADDR_W - 1);
  localparam int CNT_W = 4;

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {PORT1, PORT2} port_t;

  state_t            state, state_next;
  port_t             last_served, grant_port, port_cap;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-2:0] addr_cap;
  logic [1:0]        ds_cap;
  logic              we_cap;
  logic [15:0]       d_cap;
  logic              req_cap;
  logic              pend1, pend2, grant, complete, wr_en;
  logic [15:0]       mem [WORDS];
  logic [15:0]       rd_word;
  logic              unused_lsb;

  // Bit 0 is a byte address bit; lane selection comes only from ds.
  assign unused_lsb = port1_a[0] ^ port2_a[0];

  assign pend1 = (port1_req != port1_ack);
  assign pend2 = (port2_req != port2_ack);
  assign busy  = (state == ACCESS);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    complete   = 1'b0;
    grant_port = PORT1;
    case (state)
      IDLE: begin
        if (pend1 || pend2) begin
          grant      = 1'b1;
          state_next = ACCESS;
          if (pend1 && pend2) grant_port = (last_served == PORT1) ? PORT2 : PORT1;
          else                grant_port = pend1 ? PORT1 : PORT2;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state       <= IDLE;
      last_served <= PORT2;
      port_cap    <= PORT1;
      cnt         <= '0;
      addr_cap    <= '0;
      ds_cap      <= '0;
      we_cap      <= 1'b0;
      d_cap       <= '0;
      req_cap     <= 1'b0;
      port1_ack   <= 1'b0;
      port2_ack   <= 1'b0;
      port1_q     <= '0;
      port2_q     <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        port_cap    <= grant_port;
        last_served <= grant_port;
        cnt         <= CNT_W'(LATENCY - 1);
        if (grant_port == PORT1) begin
          addr_cap <= port1_a[ADDR_W-1:1];
          ds_cap   <= port1_ds;
          we_cap   <= port1_we;
          d_cap    <= port1_d;
          req_cap  <= port1_req;
        end else begin
          addr_cap <= port2_a[ADDR_W-1:1];
          ds_cap   <= port2_ds;
          we_cap   <= port2_we;
          d_cap    <= port2_d;
          req_cap  <= port2_req;
        end
      end else if (busy && !complete) begin
        cnt <= cnt - 4'd1;
      end

      if (complete) begin
        if (port_cap == PORT1) begin
          port1_ack <= req_cap;
          if (!we_cap) port1_q <= rd_word;
        end else begin
          port2_ack <= req_cap;
          if (!we_cap) port2_q <= rd_word;
        end
      end
    end
  end

  assign wr_en = complete && we_cap;

  // NOTE: the RAM array has no reset, so contents survive init_n and the array maps onto block RAM.
  // rd_word trails addr_cap by one edge; with LATENCY >= 2 it holds the captured word by completion.
  always_ff @(posedge clk) begin
    if (wr_en && ds_cap[0]) mem[addr_cap][7:0]  <= d_cap[7:0];
    if (wr_en && ds_cap[1]) mem[addr_cap][15:8] <= d_cap[15:8];
    rd_word <= mem[addr_cap];
  end

endmodule
